// File: rtl/alpha_calc_seq.sv
// alpha_calc_seq: sequential alpha-factor engine for the visible-watermark path.
// A_k = sat((max(A_max-A_min,0)*pow(mu_k) + A_min*sigma_k) / DIV), where
// pow(mu_k) = POW_ONE >> mu_k when mu_k < POW_W, otherwise 0.
// A restoring divider retires one quotient bit per clock, MSB first.
//
//  state  | meaning
//  IDLE   | in_ready high, waiting for in_valid
//  LOAD   | form the numerator from the captured operands
//  DIV    | one restoring divide step per clock, NUM_W steps
//  DONE   | result held on out_valid until out_ready
module alpha_calc_seq #(
    parameter int MU_SIZE = 10,
    parameter int A_W     = 7,
    parameter int SIG_W   = 7,
    parameter int POW_W   = 8,
    parameter int DIV     = 100,
    parameter int IDX_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     A_max,
    input  logic [A_W-1:0]     A_min,
    input  logic [MU_SIZE-1:0] mu_k,
    input  logic [SIG_W-1:0]   sigma_k,
    input  logic [IDX_W-1:0]   in_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W-1:0]     A_k,
    output logic [IDX_W-1:0]   out_idx,
    output logic               sat,
    output logic               busy
);

    localparam int NUM_W = ((A_W + POW_W) > (A_W + SIG_W) ? (A_W + POW_W) : (A_W + SIG_W)) + 1;
    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [POW_W-1:0] POW_ONE = POW_W'(1) << (POW_W - 1);
    localparam logic [NUM_W:0]   DIV_W   = (NUM_W + 1)'(DIV);
    localparam logic [NUM_W-1:0] AK_MAX  = NUM_W'((1 << A_W) - 1);

    if (DIV < 1) begin : g_div_check
        $error("alpha_calc_seq: DIV must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

    state_t             state;
    logic [A_W-1:0]     a_max_r;
    logic [A_W-1:0]     a_min_r;
    logic [MU_SIZE-1:0] mu_r;
    logic [SIG_W-1:0]   sigma_r;
    logic [IDX_W-1:0]   idx_r;
    logic [NUM_W-1:0]   rem;
    logic [NUM_W-1:0]   quo;
    logic [CNT_W-1:0]   cnt;

    logic [A_W-1:0]     diff;
    logic [POW_W-1:0]   pow;
    logic [NUM_W-1:0]   num;
    logic [NUM_W:0]     part;
    logic [NUM_W-1:0]   rem_next;
    logic [NUM_W-1:0]   quo_next;

    // Numerator from captured operands and the next restoring divide step.
    always_comb begin
        diff     = '0;
        pow      = '0;
        num      = '0;
        part     = '0;
        rem_next = '0;
        quo_next = '0;
        if (a_max_r >= a_min_r) diff = a_max_r - a_min_r;
        if (32'(mu_r) < 32'(POW_W)) pow = POW_ONE >> mu_r;
        num  = NUM_W'(diff) * NUM_W'(pow) + NUM_W'(a_min_r) * NUM_W'(sigma_r);
        // Partial remainder is NUM_W+1 bits: previous remainder plus next dividend bit.
        part = {rem, quo[NUM_W-1]};
        if (part >= DIV_W) begin
            rem_next = NUM_W'(part - DIV_W);
            quo_next = {quo[NUM_W-2:0], 1'b1};
        end else begin
            rem_next = NUM_W'(part);
            quo_next = {quo[NUM_W-2:0], 1'b0};
        end
    end

    // Sequencer: capture, load numerator, divide, hold result until retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            A_k       <= '0;
            out_idx   <= '0;
            sat       <= 1'b0;
            busy      <= 1'b0;
            a_max_r   <= '0;
            a_min_r   <= '0;
            mu_r      <= '0;
            sigma_r   <= '0;
            idx_r     <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_max_r  <= A_max;
                        a_min_r  <= A_min;
                        mu_r     <= mu_k;
                        sigma_r  <= sigma_k;
                        idx_r    <= in_idx;
                        sat      <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rem   <= '0;
                    quo   <= num;
                    cnt   <= CNT_W'(NUM_W - 1);
                    state <= S_DIV;
                end
                S_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    // Down-counter terminal count marks the final quotient bit.
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        out_idx   <= idx_r;
                        sat       <= (quo_next > AK_MAX);
                        A_k       <= (quo_next > AK_MAX) ? '1 : quo_next[A_W-1:0];
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alpha_calc_seq.sv
// Directed bench for alpha_calc_seq with hand-computed expected values.
module tb_alpha_calc_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  A_max;
    logic [6:0]  A_min;
    logic [9:0]  mu_k;
    logic [6:0]  sigma_k;
    logic [11:0] in_idx;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  A_k;
    logic [11:0] out_idx;
    logic        sat;
    logic        busy;

    int n_chk;
    int n_pass;

    alpha_calc_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_max     (A_max),
        .A_min     (A_min),
        .mu_k      (mu_k),
        .sigma_k   (sigma_k),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_k       (A_k),
        .out_idx   (out_idx),
        .sat       (sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Wait for in_ready, present one operand set for a single accept edge,
    // then scramble the operands to show they no longer matter.
    task automatic start_op(input logic [6:0] amax, input logic [6:0] amin,
                            input logic [9:0] mu, input logic [6:0] sig,
                            input logic [11:0] idx);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        A_max    = amax;
        A_min    = amin;
        mu_k     = mu;
        sigma_k  = sig;
        in_idx   = idx;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A_max    = 7'($urandom);
        A_min    = 7'($urandom);
        mu_k     = 10'($urandom);
        sigma_k  = 7'($urandom);
        in_idx   = 12'($urandom);
    endtask

    task automatic wait_result(input string tag, input int exp_ak, input int exp_sat, input int exp_idx);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd17);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ak"}, 32'(A_k), 32'(exp_ak));
        check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
        check({tag, "_idx"}, 32'(out_idx), 32'(exp_idx));
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_retired_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_retired_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A_max     = '0;
        A_min     = '0;
        mu_k      = '0;
        sigma_k   = '0;
        in_idx    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ak", 32'(A_k), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // num = 80*64 + 20*10 = 5320 -> 53
        start_op(7'd100, 7'd20, 10'd1, 7'd10, 12'd11);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        wait_result("t1", 53, 0, 11);
        retire("t1");

        // mu=0: 80*128 + 200 = 10440 -> 104
        start_op(7'd100, 7'd20, 10'd0, 7'd10, 12'd21);
        wait_result("t2a", 104, 0, 21);
        retire("t2a");
        // pow = 0 for mu >= POW_W: 200 -> 2
        start_op(7'd100, 7'd20, 10'd8, 7'd10, 12'd22);
        wait_result("t2b", 2, 0, 22);
        retire("t2b");
        start_op(7'd100, 7'd20, 10'd1023, 7'd10, 12'd23);
        wait_result("t2c", 2, 0, 23);
        retire("t2c");
        // pow = 1 at mu = 7: 80 + 200 = 280 -> 2
        start_op(7'd100, 7'd20, 10'd7, 7'd10, 12'd24);
        wait_result("t2d", 2, 0, 24);
        retire("t2d");

        // 127*128 = 16256 -> 162 saturates to 127
        start_op(7'd127, 7'd0, 10'd0, 7'd0, 12'd31);
        wait_result("t3", 127, 1, 31);
        retire("t3");
        check("t3_sat_held_idle", 32'(sat), 32'd1);

        // diff clamped to 0: 50*4 = 200 -> 2; sat cleared on accept
        start_op(7'd10, 7'd50, 10'd0, 7'd4, 12'd41);
        check("t4_sat_cleared", 32'(sat), 32'd0);
        wait_result("t4", 2, 0, 41);
        retire("t4");

        // Back-pressure: result must hold while in_valid is pulsed
        start_op(7'd100, 7'd20, 10'd1, 7'd10, 12'd77);
        wait_result("t5", 53, 0, 77);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_idx   = 12'd99;
            A_max    = 7'd127;
            A_min    = 7'd0;
            mu_k     = 10'd0;
            sigma_k  = 7'd0;
        end
        @(posedge clk);
        #1;
        check("t5_hold_valid", 32'(out_valid), 32'd1);
        check("t5_hold_ak", 32'(A_k), 32'd53);
        check("t5_hold_idx", 32'(out_idx), 32'd77);
        check("t5_hold_in_ready", 32'(in_ready), 32'd0);
        check("t5_hold_sat", 32'(sat), 32'd0);
        // Retire with in_valid high in the same cycle: new input not taken
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("t5_retire_valid", 32'(out_valid), 32'd0);
        check("t5_retire_busy", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_queue_valid", 32'(out_valid), 32'd0);
        check("t5_no_queue_busy", 32'(busy), 32'd0);

        // Reset mid-DIV discards the in-flight result
        start_op(7'd127, 7'd0, 10'd0, 7'd0, 12'd3);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ak", 32'(A_k), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_op(7'd100, 7'd20, 10'd1, 7'd10, 12'd5);
        wait_result("t6", 53, 0, 5);
        retire("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
